// File: rtl/alu_result_buffer_pkg.sv
// Shared types and constants for the ALU result buffer.
// Op encodings, flag bit positions and the stored entry layout.
package alu_result_buffer_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011
  } alu_op_e;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int OP_W    = 3;
  localparam int RES_W   = 4;
  localparam int FLAGS_W = 4;
  localparam int ENTRY_W = OP_W + RES_W + FLAGS_W;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [RES_W-1:0]   result;
    logic [FLAGS_W-1:0] flags;
  } entry_t;

endpackage

// File: rtl/alu_flag_encode.sv
// Combinational {Z,N,C,V} encoder for one ALU result.
// C and V come from the adder or subtractor only for ADD/SUB.
module alu_flag_encode
  import alu_result_buffer_pkg::*;
(
  input  logic [2:0] op,
  input  logic [3:0] result,
  input  logic       add_cout,
  input  logic       add_ovf,
  input  logic       sub_cout,
  input  logic       sub_ovf,
  output logic [3:0] flags
);

  // Z/N from the result, C/V selected by opcode
  always_comb begin
    flags         = '0;
    flags[FLAG_Z] = (result == 4'd0);
    flags[FLAG_N] = result[3];
    unique case (1'b1)
      (op == OP_ADD): begin
        flags[FLAG_C] = add_cout;
        flags[FLAG_V] = add_ovf;
      end
      (op == OP_SUB): begin
        flags[FLAG_C] = sub_cout;
        flags[FLAG_V] = sub_ovf;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_result_buffer.sv
// FIFO of ALU results with flags computed at push time.
// Optional STICKY_FLAGS_EN adds sticky_clr / sticky_cv.
module alu_result_buffer
  import alu_result_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [3:0]               in_result,
  input  logic                     in_add_cout,
  input  logic                     in_add_ovf,
  input  logic                     in_sub_cout,
  input  logic                     in_sub_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_result,
  output logic [3:0]               out_flags,
  output logic [2:0]               out_op,
`ifdef STICKY_FLAGS_EN
  input  logic                     sticky_clr,
  output logic [1:0]               sticky_cv,
`endif
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err_op
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if ((DEPTH < 2) || (DEPTH > 16) ||
      ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH must be a power of two in 2..16");
  end

  entry_t        mem [DEPTH];
  entry_t        hold_q;
  entry_t        head;
  entry_t        wr_entry;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic [3:0]    flags;
  logic          accept;
  logic          push;
  logic          pop;

  alu_flag_encode u_flags (
    .op       (in_op),
    .result   (in_result),
    .add_cout (in_add_cout),
    .add_ovf  (in_add_ovf),
    .sub_cout (in_sub_cout),
    .sub_ovf  (in_sub_ovf),
    .flags    (flags)
  );

  assign in_ready  = (cnt != FULL);
  assign out_valid = (cnt != '0);
  assign count     = cnt;
  assign accept    = in_valid && in_ready;
  assign push      = accept && !in_op[2];
  assign pop       = out_valid && out_ready;

  assign wr_entry.op     = in_op;
  assign wr_entry.result = in_result;
  assign wr_entry.flags  = flags;

  // Head is read straight from storage; when empty show the last head
  assign head       = out_valid ? mem[rptr] : hold_q;
  assign out_op     = head.op;
  assign out_result = head.result;
  assign out_flags  = head.flags;

  // Entry storage, written on accepted legal pushes only
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wr_entry;
  end

  // Pointers, occupancy, illegal-op pulse and last-shown head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr   <= '0;
      rptr   <= '0;
      cnt    <= '0;
      err_op <= 1'b0;
      hold_q <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      err_op <= accept && in_op[2];
      if (out_valid) hold_q <= mem[rptr];
    end
  end

`ifdef STICKY_FLAGS_EN
  // Accumulate C/V of accepted pushes; clear wins over set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_cv <= 2'b00;
    end else if (sticky_clr) begin
      sticky_cv <= 2'b00;
    end else if (push) begin
      sticky_cv <= sticky_cv | {flags[FLAG_C], flags[FLAG_V]};
    end
  end
`endif

endmodule

// File: doc/alu_result_buffer.md
ALU_RESULT_BUFFER -- requirements
Module: alu_result_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning FIFO entry count; the value SHALL be a power of two, 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1): the upstream push handshake.
REQ-005 The block SHALL have ports in_op (input, 3) and in_result (input, 4): the ALU opcode and its result.
REQ-006 The block SHALL have ports in_add_cout, in_add_ovf, in_sub_cout and in_sub_ovf (input, 1 each): the adder and subtractor carry and overflow.
REQ-007 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): the downstream pop handshake.
REQ-008 The block SHALL have ports out_result (output, 4), out_flags (output, 4, {Z,N,C,V}) and out_op (output, 3).
REQ-009 The block SHALL have ports count (output, clog2(DEPTH)+1 bits): current occupancy; and err_op (output, 1): one-cycle illegal-op pulse.

Function
REQ-010 A push SHALL occur when in_valid && in_ready && in_op[2]==0.
REQ-011 A pop SHALL occur when out_valid && out_ready.
REQ-012 Flag C SHALL be set as follows:
- op 000: in_add_cout
- op 001: in_sub_cout
- op 010 and 011: 0
REQ-013 Flag V SHALL be set as follows:
- op 000: in_add_ovf
- op 001: in_sub_ovf
- op 010 and 011: 0
REQ-014 Flag Z SHALL be (in_result==0) and flag N SHALL be in_result[3]; both SHALL be computed at push time and stored with the entry.
REQ-015 in_op[2]==1 with in_valid && in_ready SHALL store nothing and SHALL assert err_op for exactly the next cycle.
REQ-016 in_ready SHALL equal (count != DEPTH) and SHALL NOT depend on out_ready.
REQ-017 out_valid SHALL equal (count != 0).
REQ-018 out_result, out_flags and out_op SHALL present the head entry with zero-cycle read latency.
REQ-019 A pushed entry SHALL become visible on out_* one cycle after the push edge.
REQ-020 When empty, out_result, out_flags and out_op SHALL hold their last driven values; out_valid SHALL be 0.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, SHALL preserve order and SHALL be legal at any non-empty, non-full level.
REQ-022 Simultaneous push and pop when full SHALL be impossible, because in_ready=0.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH with no gap or duplication.

Reset
REQ-024 On rst assertion the block SHALL immediately clear count, pointers, out_valid, err_op, out_result, out_flags and out_op to 0 and set in_ready to 1.
REQ-025 Entries in flight at reset SHALL be discarded.
REQ-026 The first push SHALL be accepted on the first clk edge after rst deasserts.

Configuration
REQ-027 With STICKY_FLAGS_EN defined, the block SHALL add output sticky_cv (2 bits: {C,V}) that ORs the C and V flags of every accepted push.
REQ-028 sticky_cv SHALL clear only on rst or on input sticky_clr (1 bit); sticky_clr SHALL take priority over a same-cycle set.
REQ-029 Without STICKY_FLAGS_EN, sticky_cv and sticky_clr SHALL NOT exist and behaviour SHALL be otherwise identical.

Structure
REQ-030 A shared package SHALL hold:
- op encodings (ADD=000, SUB=001, AND=010, OR=011)
- flag bit indices (Z=3, N=2, C=1, V=0)
- the entry width constant (11 bits: op+result+flags)
REQ-031 The flag encoder SHALL be one sub-module, alu_flag_encode (combinational), instantiated once; storage and pointers SHALL stay in alu_result_buffer.

Verification
REQ-032 Reset followed by a push of op=000, result=0000, add_cout=1, add_ovf=0 SHALL yield, next cycle, out_valid=1, out_flags=1010, count=1.
REQ-033 Five pushes with DEPTH=4 and out_ready=0 SHALL give in_ready=0 after the 4th push; the 5th SHALL be held off; count=4.
REQ-034 When full, one pop SHALL give in_ready=1 next cycle; a simultaneous push/pop at count=2 SHALL keep count=2; order SHALL be preserved across 10 wraps.
REQ-035 A push of op=101 SHALL pulse err_op for exactly one cycle with count unchanged; op=001, result=1000, sub_ovf=1 SHALL store flags 0101.
REQ-036 rst asserted mid-stream with count=3 SHALL give count=0 and out_valid=0 asynchronously, before the next clk edge.
REQ-037 With STICKY_FLAGS_EN defined, one add_cout=1 push SHALL set sticky_cv=10 until sticky_clr; a sticky_clr coincident with a V push SHALL yield 00.
